truth_table_checker: RTL
========================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 4, giving the cycles each input vector is held before F/Fs are sampled (legal 1..255).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle run request, honoured only when busy=0.
REQ-005 SHALL have port exp_f, input, 8, expected F; bit i is the expectation for {A,B,C}=i.
REQ-006 SHALL have port exp_fs, input, 8, expected Fs, indexed the same way as exp_f.
REQ-007 SHALL have ports A, B and C, each output, 1, the stimulus driven to the device under test (A=MSB).
REQ-008 SHALL have ports F and Fs, each input, 1, the device-under-test responses.
REQ-009 SHALL have port busy, output, 1, high while a run is in progress.
REQ-010 SHALL have port done, output, 1, a level held high from run completion until the next accepted start or reset.
REQ-011 SHALL have port pass, output, 1, equal to done AND both fail masks zero.
REQ-012 SHALL have ports fail_mask_f and fail_mask_fs, each output, 8, where bit i is set if vector i mismatched.
REQ-013 SHALL have port err_count, output, 5, the total number of mismatched bits (0..16).

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE and DONE.
REQ-015 SHALL, on start in IDLE or DONE, go to DRIVE with vec=0, settle count=0, masks and err_count cleared, done=0 and busy=1 on the next cycle.
REQ-016 SHALL latch exp_f and exp_fs on the accepted start edge; later changes to them SHALL NOT affect the run.
REQ-017 SHALL drive {A,B,C}=vec throughout DRIVE.
REQ-018 SHALL increment the settle count each DRIVE cycle; at the edge where count==SETTLE-1 it SHALL sample F and Fs and compare them against latched bit vec.
REQ-019 SHALL, on that sample edge, set fail_mask_f[vec] if F differs and fail_mask_fs[vec] if Fs differs, adding 0, 1 or 2 to err_count.
REQ-020 SHALL, on that sample edge, go to DONE if vec==7; otherwise it SHALL increment vec and reset the count to 0.
REQ-021 SHALL keep busy high for exactly 8*SETTLE cycles on a full run.
REQ-022 SHALL, in DONE, assert busy=0 and done=1, hold {A,B,C} at the last driven vector, and hold the results until the next start.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL return {A,B,C} to 000 in IDLE.

Reset
REQ-025 SHALL, with rst high at a clock edge (including mid-run), force state IDLE, vec=0, {A,B,C}=000, busy=0, done=0, pass=0, masks=0 and err_count=0 on the next cycle.
REQ-026 SHALL give rst priority over start when both are high on the same edge.

Configuration
REQ-027 SHALL, with macro TTC_STOP_ON_FAIL_EN defined, go to DONE on the first sample edge with any mismatch, leaving later mask bits 0 and holding {A,B,C} at the failing vector.
REQ-028 SHALL, without TTC_STOP_ON_FAIL_EN, always run all 8 vectors.

Verification
REQ-029 SHALL cover a full pass run: SETTLE=4, DUT F=A^B^C and Fs=majority, exp_f=0x96, exp_fs=0xE8, pulse start -> busy for 32 cycles, then done=1, pass=1, masks=0x00, err_count=0.
REQ-030 SHALL cover a single F mismatch: same DUT with exp_f=0x97 -> fail_mask_f=0x01, fail_mask_fs=0x00, err_count=1, pass=0.
REQ-031 SHALL cover a stuck Fs: DUT Fs tied to 0, exp_fs=0xE8 -> fail_mask_fs=0xE8, err_count=4, pass=0.
REQ-032 SHALL cover a busy-time start plus input change: start re-pulsed and exp_f changed to 0x00 at cycle 10 -> results and timing identical to REQ-029.
REQ-033 SHALL cover reset mid-run: rst at cycle 12 -> next cycle busy=0, {A,B,C}=000, masks=0, err_count=0; a new start then reproduces REQ-029.
REQ-034 SHALL cover stop-on-fail: with TTC_STOP_ON_FAIL_EN, the REQ-031 stimulus -> done after 16 busy cycles, fail_mask_fs=0x08, {A,B,C}=011, err_count=1.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Walks a 3-input combinational device through all eight input vectors,
//   holds each vector for SETTLE cycles, then samples the F and Fs responses
//   and compares them against expected truth tables latched at start.
//
//   Parameters
//     SETTLE       cycles each vector is held before sampling (1..255)
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     start        one-cycle run request, honoured only when not busy
//     exp_f        expected F truth table, bit i for {A,B,C}=i
//     exp_fs       expected Fs truth table, same indexing
//     A, B, C      stimulus to the device under test (A is MSB)
//     F, Fs        device-under-test responses
//     busy         high while a run is in progress
//     done         high from run completion until next accepted start/reset
//     pass         done with both fail masks clear
//     fail_mask_f  bit i set if F mismatched on vector i
//     fail_mask_fs bit i set if Fs mismatched on vector i
//     err_count    total mismatched bits (0..16)
//
//   Optional feature: define TTC_STOP_ON_FAIL_EN to end the run on the first
//   sample edge that shows any mismatch.
module truth_table_checker #(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] exp_f,
   input  logic [7:0] exp_fs,
   output logic       A,
   output logic       B,
   output logic       C,
   input  logic       F,
   input  logic       Fs,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask_f,
   output logic [7:0] fail_mask_fs,
   output logic [4:0] err_count
);

   typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

   state_e     state_q, state_d;
   logic [2:0] vec_q, vec_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] exp_f_q, exp_f_d;
   logic [7:0] exp_fs_q, exp_fs_d;
   logic [7:0] mask_f_q, mask_f_d;
   logic [7:0] mask_fs_q, mask_fs_d;
   logic [4:0] err_q, err_d;

   logic sample;
   logic mis_f;
   logic mis_fs;
   logic stop;

   localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

   always_comb begin
      sample = (cnt_q == SettleLast);
      mis_f  = F ^ exp_f_q[vec_q];
      mis_fs = Fs ^ exp_fs_q[vec_q];
`ifdef TTC_STOP_ON_FAIL_EN
      stop   = mis_f | mis_fs;
`else
      stop   = 1'b0;
`endif
   end

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      cnt_d     = cnt_q;
      exp_f_d   = exp_f_q;
      exp_fs_d  = exp_fs_q;
      mask_f_d  = mask_f_q;
      mask_fs_d = mask_fs_q;
      err_d     = err_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StDrive;
               vec_d     = 3'd0;
               cnt_d     = 8'd0;
               exp_f_d   = exp_f;
               exp_fs_d  = exp_fs;
               mask_f_d  = 8'h00;
               mask_fs_d = 8'h00;
               err_d     = 5'd0;
            end
         end
         StDrive: begin
            if (sample) begin
               mask_f_d[vec_q]  = mis_f;
               mask_fs_d[vec_q] = mis_fs;
               err_d = err_q + {4'd0, mis_f} + {4'd0, mis_fs};
               if ((vec_q == 3'd7) || stop) begin
                  // vec is left alone so the last (or failing) vector stays driven
                  state_d = StDone;
               end else begin
                  vec_d = vec_q + 3'd1;
                  cnt_d = 8'd0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         vec_q     <= 3'd0;
         cnt_q     <= 8'd0;
         exp_f_q   <= 8'h00;
         exp_fs_q  <= 8'h00;
         mask_f_q  <= 8'h00;
         mask_fs_q <= 8'h00;
         err_q     <= 5'd0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         cnt_q     <= cnt_d;
         exp_f_q   <= exp_f_d;
         exp_fs_q  <= exp_fs_d;
         mask_f_q  <= mask_f_d;
         mask_fs_q <= mask_fs_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      busy         = (state_q == StDrive);
      done         = (state_q == StDone);
      pass         = done && (mask_f_q == 8'h00) && (mask_fs_q == 8'h00);
      {A, B, C}    = (state_q == StIdle) ? 3'b000 : vec_q;
      fail_mask_f  = mask_f_q;
      fail_mask_fs = mask_fs_q;
      err_count    = err_q;
   end

endmodule
